// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - instruction fetch, ALU operand/result and data memory bus bundle
interface cpu_sequencer_if;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;

    logic [7:0] alu_instr;
    logic [7:0] alu_pc;
    logic [7:0] alu_in0;
    logic [7:0] alu_in1;
    logic [7:0] alu_out;
    logic [7:0] alu_jump;
    logic       alu_overflow;

    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic       dmem_ack;
    logic [7:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output alu_instr, alu_pc, alu_in0, alu_in1,
        input  alu_out, alu_jump, alu_overflow,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  alu_instr, alu_pc, alu_in0, alu_in1,
        output alu_out, alu_jump, alu_overflow,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute sequencer with 4-entry register file
module cpu_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [1:0] LINK_REG = 2'd3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    cpu_sequencer_if.master       bus,
    output logic                  busy,
    output logic                  ovf_flag
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_RESULT, S_MEM, S_WB
    } state_t;

    state_t     state, state_nx;
    logic [7:0] pc, ir, res;
    logic       jmp;
    logic       ovf_cap;
    logic [7:0] rf [4];

    logic [3:0] opcode;
    logic [1:0] ra, rb;
    logic       is_mem, is_jump, is_branch, writes_ra;

    assign opcode = ir[7:4];
    assign ra     = ir[3:2];
    assign rb     = ir[1:0];

    assign is_mem    = (opcode == 4'hA) || (opcode == 4'hB);
    assign is_jump   = (opcode == 4'h8) || (opcode == 4'h9);
    assign is_branch = (opcode == 4'hC) || (opcode == 4'hD);
    assign writes_ra = (opcode <= 4'h7) || (opcode == 4'hA) || (opcode == 4'hE) || (opcode == 4'hF);

    // Operands follow IR and the register file; both are frozen from DECODE through RESULT.
    assign bus.alu_in0    = rf[ra];
    assign bus.alu_in1    = rf[rb];
    assign bus.alu_pc     = pc;
    assign bus.imem_addr  = pc;
    assign bus.dmem_addr  = rf[rb];
    assign bus.dmem_wdata = rf[ra];
    assign busy           = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state and per-state strobes; requests are state-exclusive so imem/dmem never overlap.
    always_comb begin
        state_nx      = state;
        bus.imem_req  = 1'b0;
        bus.dmem_req  = 1'b0;
        bus.dmem_we   = 1'b0;
        bus.alu_instr = 8'h00;
        case (state)
            S_IDLE:   if (run) state_nx = S_FETCH;
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) state_nx = S_DECODE;
            end
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                bus.alu_instr = ir;
                state_nx      = S_RESULT;
            end
            S_RESULT: state_nx = is_mem ? S_MEM : S_WB;
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (opcode == 4'hB);
                if (bus.dmem_ack) state_nx = S_WB;
            end
            S_WB:     state_nx = run ? S_FETCH : S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Datapath: IR latch, ALU/load result capture, register write-back, PC update, sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            ir       <= 8'h00;
            res      <= 8'h00;
            jmp      <= 1'b0;
            ovf_cap  <= 1'b0;
            ovf_flag <= 1'b0;
            for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
        end else begin
            case (state)
                S_FETCH: if (bus.imem_ack) ir <= bus.imem_data;
                S_RESULT: begin
                    res     <= bus.alu_out;
                    jmp     <= (bus.alu_jump == 8'hFF);
                    ovf_cap <= bus.alu_overflow;
                end
                S_MEM: if (bus.dmem_ack && opcode == 4'hA) res <= bus.dmem_rdata;
                S_WB: begin
                    if (writes_ra)            rf[ra]       <= res;
                    else if (opcode == 4'h9)  rf[LINK_REG] <= pc + 8'd1;
                    // Jump targets arrive as an offset from the following instruction.
                    if (is_jump && jmp)        pc <= pc + 8'd1 + res;
                    else if (is_branch && jmp) pc <= pc + 8'd2;
                    else                       pc <= pc + 8'd1;
                    if (opcode == 4'h1 && ovf_cap) ovf_flag <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic run;
    logic busy;
    logic ovf_flag;
    int   checks = 0;
    int   failures = 0;
    int   excl_viol = 0;

    cpu_sequencer_if bus ();

    cpu_sequencer #(.RESET_PC(8'h00), .LINK_REG(2'd3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .bus      (bus),
        .busy     (busy),
        .ovf_flag (ovf_flag)
    );

    always #5 clk = ~clk;

    // Reference ALU: registers its result every edge from whatever alu_instr presents.
    always @(posedge clk) begin
        logic [7:0] s;
        s = bus.alu_in0 + bus.alu_in1;
        bus.alu_out      <= bus.alu_in1;
        bus.alu_jump     <= 8'h00;
        bus.alu_overflow <= 1'b0;
        case (bus.alu_instr[7:4])
            4'h1: begin
                bus.alu_out      <= s;
                bus.alu_overflow <= (bus.alu_in0[7] == bus.alu_in1[7]) && (s[7] != bus.alu_in0[7]);
            end
            4'hF: bus.alu_out <= {6'b0, bus.alu_instr[1:0]};
            4'h8, 4'h9: begin
                bus.alu_out  <= bus.alu_in1 - bus.alu_pc - 8'd1;
                bus.alu_jump <= 8'hFF;
            end
            4'hC: bus.alu_jump <= (bus.alu_in0 == bus.alu_in1) ? 8'hFF : 8'h00;
            4'hD: bus.alu_jump <= (bus.alu_in0 != bus.alu_in1) ? 8'hFF : 8'h00;
            default: ;
        endcase
    end

    always @(negedge clk) if (bus.imem_req && bus.dmem_req) excl_viol++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Serves one fetch with instr, answers a data access after dly request cycles, stops at next FETCH.
    task automatic run_instr(input logic [7:0] instr, input logic [7:0] rd, input int dly,
                             output logic [7:0] faddr, output int cycles, output int dreq,
                             output logic dwe, output logic [7:0] daddr, output logic [7:0] dwdata);
        int guard = 0;
        dwe = 1'b0; daddr = 8'h00; dwdata = 8'h00; dreq = 0; cycles = 0;
        while (!bus.imem_req && guard < 20) begin @(negedge clk); guard++; end
        if (!bus.imem_req) check_eq("fetch_timeout", bus.imem_req, 1);
        faddr = bus.imem_addr;
        bus.imem_data = instr;
        bus.imem_ack  = 1'b1;
        do begin
            @(negedge clk);
            cycles++;
            bus.imem_ack = 1'b0;
            bus.dmem_ack = 1'b0;
            if (bus.dmem_req) begin
                dreq++;
                if (dreq >= dly) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = rd;
                    dwe    = bus.dmem_we;
                    daddr  = bus.dmem_addr;
                    dwdata = bus.dmem_wdata;
                end
            end
        end while (!bus.imem_req && busy && cycles < 40);
        if (cycles >= 40) check_eq("instr_timeout", cycles, 0);
    endtask

    task automatic ld(input logic [7:0] instr, input logic [7:0] rd);
        logic [7:0] fa, da, wd;
        int cy, dq;
        logic we;
        run_instr(instr, rd, 1, fa, cy, dq, we, da, wd);
        check_eq("lw_cycles", cy, 6);
        check_eq("lw_we", we, 0);
    endtask

    initial begin
        logic [7:0] fa, da, wd;
        int cy, dq;
        logic we;

        rst_n = 1'b0; run = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_data = 8'h00;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_imem_req", bus.imem_req, 0);
        check_eq("rst_dmem_req", bus.dmem_req, 0);
        check_eq("rst_dmem_we", bus.dmem_we, 0);
        check_eq("rst_alu_instr", bus.alu_instr, 8'h00);
        check_eq("rst_ovf", ovf_flag, 0);
        check_eq("rst_pc", dut.pc, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_hold", busy, 0);
        run = 1'b1;

        run_instr(8'hF6, 8'h00, 1, fa, cy, dq, we, da, wd);
        check_eq("li_faddr", fa, 8'h00);
        check_eq("li_cycles", cy, 5);
        check_eq("li_r1", dut.rf[1], 8'h02);
        check_eq("li_pc", dut.pc, 8'h01);

        ld(8'hA0, 8'h7F);
        check_eq("lw_r0", dut.rf[0], 8'h7F);
        ld(8'hA4, 8'h01);
        run_instr(8'h11, 8'h00, 1, fa, cy, dq, we, da, wd);
        check_eq("add_r0", dut.rf[0], 8'h80);
        check_eq("add_ovf", ovf_flag, 1);
        check_eq("add_cycles", cy, 5);

        ld(8'hA8, 8'h10);
        check_eq("jal_start_pc", dut.pc, 8'h05);
        run_instr(8'h92, 8'h00, 1, fa, cy, dq, we, da, wd);
        check_eq("jal_r3", dut.rf[3], 8'h06);
        check_eq("jal_target", bus.imem_addr, 8'h10);
        check_eq("jal_r2_kept", dut.rf[2], 8'h10);

        ld(8'hA0, 8'h33);
        ld(8'hA4, 8'h33);
        ld(8'hA8, 8'h07);
        run_instr(8'h82, 8'h00, 1, fa, cy, dq, we, da, wd);
        check_eq("j_target", bus.imem_addr, 8'h07);
        run_instr(8'hC1, 8'h00, 1, fa, cy, dq, we, da, wd);
        check_eq("beq_taken", bus.imem_addr, 8'h09);

        ld(8'hA4, 8'h34);
        run_instr(8'h82, 8'h00, 1, fa, cy, dq, we, da, wd);
        run_instr(8'hC1, 8'h00, 1, fa, cy, dq, we, da, wd);
        check_eq("beq_fallthru", bus.imem_addr, 8'h08);
        check_eq("ovf_sticky", ovf_flag, 1);

        ld(8'hA0, 8'hAA);
        ld(8'hA4, 8'h20);
        run_instr(8'hB1, 8'h00, 3, fa, cy, dq, we, da, wd);
        check_eq("sw_req_cycles", dq, 3);
        check_eq("sw_we", we, 1);
        check_eq("sw_addr", da, 8'h20);
        check_eq("sw_wdata", wd, 8'hAA);
        check_eq("sw_cycles", cy, 8);
        check_eq("sw_pc", dut.pc, 8'h0B);
        check_eq("sw_r0", dut.rf[0], 8'hAA);
        check_eq("sw_r1", dut.rf[1], 8'h20);

        ld(8'hA8, 8'hFF);
        run_instr(8'h82, 8'h00, 1, fa, cy, dq, we, da, wd);
        check_eq("j_to_ff", dut.pc, 8'hFF);
        run_instr(8'hF6, 8'h00, 1, fa, cy, dq, we, da, wd);
        check_eq("pc_wrap", dut.pc, 8'h00);

        ld(8'hA8, 8'h40);
        run_instr(8'h82, 8'h00, 1, fa, cy, dq, we, da, wd);
        check_eq("pre_rst_addr", bus.imem_addr, 8'h40);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_imem_req", bus.imem_req, 0);
        check_eq("mid_rst_pc", dut.pc, 8'h00);
        check_eq("mid_rst_ovf", ovf_flag, 0);
        for (int i = 0; i < 4; i++) check_eq("mid_rst_rf", dut.rf[i], 8'h00);
        check_eq("req_exclusive", excl_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00: PC value loaded at reset.
REQ-002 SHALL have parameter LINK_REG, default 2'd3: register written by JAL.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port run  input  1: start/continue execution; sampled in IDLE and WB.
REQ-006 SHALL have ports imem_req output 1, imem_addr output 8, imem_ack input 1, imem_data input 8: instruction fetch handshake.
REQ-007 SHALL have ports alu_instr output 8, alu_pc output 8, alu_in0 output 8, alu_in1 output 8: ALU operands.
REQ-008 SHALL have ports alu_out input 8, alu_jump input 8, alu_overflow input 1: ALU results.
REQ-009 SHALL have ports dmem_req output 1, dmem_we output 1, dmem_addr output 8, dmem_wdata output 8, dmem_ack input 1, dmem_rdata input 8: data memory handshake.
REQ-010 SHALL have ports busy output 1 (state != IDLE) and ovf_flag output 1 (sticky overflow).

Function
REQ-011 SHALL contain PC (8b), IR (8b), RES (8b), JMP (1b) and register file r0..r3 (8b each).
REQ-012 SHALL decode opcode=IR[7:4], ra=IR[3:2], rb=IR[1:0].
REQ-013 SHALL implement states IDLE, FETCH, DECODE, EXEC, RESULT, MEM, WB.
REQ-014 IDLE: -> FETCH when run=1; otherwise remain.
REQ-015 FETCH: imem_req=1, imem_addr=PC; on imem_ack=1 SHALL latch IR<=imem_data, -> DECODE; no timeout.
REQ-016 DECODE: one cycle; alu_in0=r[ra], alu_in1=r[rb] held stable from DECODE through RESULT.
REQ-017 EXEC: alu_instr=IR, alu_pc=PC; the ALU registers its result on this edge. alu_instr SHALL be 8'h00 (MOVE) in all other states.
REQ-018 RESULT: SHALL capture RES<=alu_out, JMP<=(alu_jump==8'hFF); opcode 4'hA/4'hB -> MEM, else -> WB.
REQ-019 MEM: dmem_req=1, dmem_addr=r[rb], dmem_we=(opcode==4'hB), dmem_wdata=r[ra]; on dmem_ack -> WB; LW captures RES<=dmem_rdata on ack.
REQ-020 WB register write: opcodes 0-7, 4'hA, 4'hE, 4'hF write RES to r[ra]; 4'h9 writes PC+1 to r[LINK_REG]; 4'h8, 4'hB, 4'hC, 4'hD write nothing.
REQ-021 WB PC update: J/JAL with JMP=1: PC<=PC+1+RES (= r[rb]); BEQ/BNE with JMP=1: PC<=PC+2; else PC<=PC+1; 8-bit wrap (8'hFF+1=8'h00).
REQ-022 WB: opcode 4'h1 with alu_overflow=1 captured in RESULT SHALL set ovf_flag; only reset clears it.
REQ-023 WB -> FETCH when run=1, else -> IDLE.
REQ-024 Nominal latency with single-cycle acks: 5 cycles per non-memory instruction, 6 per LW/SW.
REQ-025 imem_req and dmem_req SHALL never be asserted in the same cycle.
REQ-026 A write to r[ra] in WB SHALL be visible to the next instruction's DECODE (no bypass needed).

Reset
REQ-027 rst_n=0 at a clock edge SHALL force state=IDLE, PC=RESET_PC, IR=0, RES=0, JMP=0, r0..r3=0, ovf_flag=0.
REQ-028 During and after reset: imem_req=0, dmem_req=0, dmem_we=0, alu_instr=8'h00, busy=0.
REQ-029 Reset mid-handshake SHALL drop requests on that edge with no register or PC write.

Verification
REQ-030 Reset, run=1, imem returns 8'hF6 (LI r1,imm 2) -> imem_req at PC 0, r1=8'h02 after WB, PC=1, 5 cycles.
REQ-031 r0=8'h7F, r1=8'h01, instr 8'h11 (ADD r0,r1) -> r0=8'h80, ovf_flag=1 and stays 1 through later instructions.
REQ-032 r2=8'h10, instr 8'h92 (JAL rb=r2) at PC=8'h05 -> r3=8'h06, next fetch address 8'h10.
REQ-033 r0=r1=8'h33, instr 8'hC1 (BEQ) at PC=8'h07 -> next fetch 8'h09; r1=8'h34 -> next fetch 8'h08.
REQ-034 SW 8'hB1 with r0=8'hAA, r1=8'h20, dmem_ack delayed 3 cycles -> dmem_req held 3 cycles, dmem_we=1, addr 8'h20, wdata 8'hAA, then PC+1; no register change.
REQ-035 rst_n=0 while waiting for imem_ack with PC=8'h40 -> next cycle IDLE, PC=8'h00, imem_req=0, all registers 0.
